// File: rtl/kfps2kb_pkg.sv
// Shared types and constants for the PS/2 keyboard command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t         - sequencer FSM states
//   ACK_BYTE        - keyboard acknowledge (0xFA)
//   RESEND_BYTE     - keyboard resend request (0xFE)
//   NO_START, RETRY_EXHAUSTED, TX_HANG - error_code values
//   failure_code()  - maps the state an error is raised from to its code
package kfps2kb_pkg;

   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      ISSUE         = 3'd1,
      WAIT_TX_START = 3'd2,
      WAIT_TX_END   = 3'd3,
      WAIT_ACK      = 3'd4,
      RETRY         = 3'd5,
      ERROR         = 3'd6
   } state_t;

   localparam logic [7:0] ACK_BYTE    = 8'hFA;
   localparam logic [7:0] RESEND_BYTE = 8'hFE;

   localparam logic [1:0] NO_START        = 2'b01;
   localparam logic [1:0] RETRY_EXHAUSTED = 2'b10;
   localparam logic [1:0] TX_HANG         = 2'b11;

   // Width of the peripheral tick counter; matches the ACK_TIMEOUT parameter.
   localparam int TICK_CNT_W = 16;

   // Every path into ERROR comes from one of the three wait states, so the
   // state being left fully determines the reason for the failure.
   function automatic logic [1:0] failure_code(input state_t from_state);
      logic [1:0] code;
      case (from_state)
         WAIT_TX_START: code = NO_START;
         WAIT_TX_END:   code = TX_HANG;
         default:       code = RETRY_EXHAUSTED;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/kfps2kb_cmd_fifo.sv
// Command byte FIFO with show-ahead head output.
// Latency: a push at edge N is visible on head/empty right after edge N.
// Backpressure: push while full is dropped; pop while empty is ignored.
//
// Ports:
//   clock, reset       - system clock, async active-low reset (flushes)
//   push, push_data    - write request and byte
//   pop                - discard the current head
//   head               - oldest stored byte (valid when !empty)
//   full, empty        - derived from the occupancy count
module kfps2kb_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic push_ok;
   logic pop_ok;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so plain binary pointer overflow is the wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is read until count_q says it is valid.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/kfps2kb_command_sequencer.sv
// Issues queued host bytes to the PS/2 send stage and tracks the keyboard's ACK/RESEND reply.
// Latency: cmd_write at edge N into an idle empty block -> send_request high during cycle N+1..N+2.
// Backpressure: cmd_full blocks host pushes (extra bytes dropped); progress waits on send stage/keyboard, bounded by ACK_TIMEOUT ticks.
//
// Ports:
//   clock, reset                  - system clock, async active-low reset
//   peripheral_clock              - slow timebase, rising edges counted as timeout ticks
//   cmd_write, cmd_data, cmd_full - host command push interface
//   cmd_empty                     - no command queued
//   send_request, send_data       - one-cycle request and byte to the PS/2 send stage
//   sending_data_flag             - send stage busy
//   rx_valid, rx_data             - bytes from the PS/2 receive stage
//   ack_done, error               - one-cycle completion pulses
//   error_code                    - reason of the most recent error (held)
//   busy                          - sequencer not idle
module kfps2kb_command_sequencer
   import kfps2kb_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] ACK_TIMEOUT = 16'd2000,
   parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       peripheral_clock,
   input  logic       cmd_write,
   input  logic [7:0] cmd_data,
   output logic       cmd_full,
   output logic       cmd_empty,
   output logic       send_request,
   output logic [7:0] send_data,
   input  logic       sending_data_flag,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       ack_done,
   output logic       error,
   output logic [1:0] error_code,
   output logic       busy
);

   // ---------------------------------------------------------------
   // Peripheral clock tick detection
   // ---------------------------------------------------------------
   // Two synchroniser stages, then one more stage to find the rising edge.
   logic pclk_meta_q, pclk_sync_q, pclk_prev_q;
   logic tick;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pclk_meta_q <= 1'b0;
         pclk_sync_q <= 1'b0;
         pclk_prev_q <= 1'b0;
      end else begin
         pclk_meta_q <= peripheral_clock;
         pclk_sync_q <= pclk_meta_q;
         pclk_prev_q <= pclk_sync_q;
      end
   end

   assign tick = pclk_sync_q && !pclk_prev_q;

   // ---------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------
   logic       fifo_pop;
   logic [7:0] fifo_head;
   logic       fifo_full;
   logic       fifo_empty;

   kfps2kb_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_cmd_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (cmd_write),
      .push_data (cmd_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign cmd_full  = fifo_full;
   assign cmd_empty = fifo_empty;

   // ---------------------------------------------------------------
   // Sequencer state and datapath registers
   // ---------------------------------------------------------------
   state_t                state_q, state_d;
   logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]            retry_q, retry_d;
   logic [7:0]            send_data_q, send_data_d;
   logic [1:0]            err_code_q, err_code_d;
   logic                  ack_done_q, ack_done_d;

   logic timeout;
   logic rx_ack;
   logic rx_resend;

   assign timeout   = (tick_cnt_q >= ACK_TIMEOUT);
   assign rx_ack    = rx_valid && (rx_data == ACK_BYTE);
   assign rx_resend = rx_valid && (rx_data == RESEND_BYTE);

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT_TX_START;
         end
         WAIT_TX_START: begin
            if (sending_data_flag) begin
               state_d = WAIT_TX_END;
            end else if (timeout) begin
               state_d = ERROR;
            end
         end
         WAIT_TX_END: begin
            if (!sending_data_flag) begin
               state_d = WAIT_ACK;
            end else if (timeout) begin
               state_d = ERROR;
            end
         end
         WAIT_ACK: begin
            // Bytes other than ACK/RESEND leave the state (and the
            // running timeout) untouched.
            if (rx_ack) begin
               state_d = IDLE;
            end else if (rx_resend || timeout) begin
               state_d = (retry_q < MAX_RETRY) ? RETRY : ERROR;
            end
         end
         RETRY: begin
            state_d = ISSUE;
         end
         ERROR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath next values and FIFO pop
   always_comb begin
      send_data_d = send_data_q;
      retry_d     = retry_q;
      err_code_d  = err_code_q;
      ack_done_d  = 1'b0;
      fifo_pop    = 1'b0;

      // Each wait state gets a fresh timeout window; the tick counter
      // saturates so a long stall can never wrap back under the limit.
      if (state_d != state_q) begin
         tick_cnt_d = '0;
      end else if (tick && (tick_cnt_q != '1)) begin
         tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
      end else begin
         tick_cnt_d = tick_cnt_q;
      end

      unique case (state_q)
         IDLE: begin
            // Peek only: the byte stays queued until the command resolves.
            if (!fifo_empty) begin
               send_data_d = fifo_head;
               retry_d     = 2'd0;
            end
         end
         WAIT_ACK: begin
            if (rx_ack) begin
               fifo_pop   = 1'b1;
               ack_done_d = 1'b1;
            end
         end
         RETRY: begin
            retry_d = retry_q + 2'd1;
         end
         ERROR: begin
            fifo_pop = 1'b1;
         end
         default: begin
         end
      endcase

      // Latch the reason on the way into ERROR so it is already valid in
      // the cycle the error pulse is shown, and stays until the next one.
      if ((state_d == ERROR) && (state_q != ERROR)) begin
         err_code_d = failure_code(state_q);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_cnt_q  <= '0;
         retry_q     <= 2'd0;
         send_data_q <= 8'h00;
         err_code_q  <= 2'b00;
         ack_done_q  <= 1'b0;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         retry_q     <= retry_d;
         send_data_q <= send_data_d;
         err_code_q  <= err_code_d;
         ack_done_q  <= ack_done_d;
      end
   end

   // Output decode. send_request is tied to the ISSUE state, which always
   // lasts one cycle and is never entered twice in a row, so every issue
   // is a separate one-cycle pulse.
   always_comb begin
      send_request = (state_q == ISSUE);
      busy         = (state_q != IDLE);
      error        = (state_q == ERROR);
   end

   assign send_data  = send_data_q;
   assign error_code = err_code_q;
   assign ack_done   = ack_done_q;

endmodule

// File: tb/tb_kfps2kb_command_sequencer.sv
module tb_kfps2kb_command_sequencer;

   localparam int TB_MAX_RETRY = 3;

   // Keyboard behaviour for one issue of a command
   localparam int R_ACK      = 0;  // ACK after the transfer
   localparam int R_RESEND   = 1;  // RESEND after the transfer
   localparam int R_SILENT   = 2;  // transfer completes, no reply at all
   localparam int R_NOSTART  = 3;  // send stage never starts
   localparam int R_HANG     = 4;  // send stage never finishes
   localparam int R_JUNK_ACK = 5;  // unrelated byte, then ACK

   // Completion events seen by the monitor
   localparam logic [2:0] EV_ACK     = 3'b100;
   localparam logic [2:0] EV_NOSTART = 3'b001;
   localparam logic [2:0] EV_EXH     = 3'b010;
   localparam logic [2:0] EV_HANG    = 3'b011;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       peripheral_clock = 1'b0;
   logic       cmd_write = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_full;
   logic       cmd_empty;
   logic       send_request;
   logic [7:0] send_data;
   logic       sending_data_flag = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       ack_done;
   logic       error;
   logic [1:0] error_code;
   logic       busy;

   always #5 clock = ~clock;
   always #20 peripheral_clock = ~peripheral_clock;  // one tick per 4 clocks

   kfps2kb_command_sequencer #(
      .FIFO_DEPTH  (4),
      .ACK_TIMEOUT (16'd2000),
      .MAX_RETRY   (2'd3)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .peripheral_clock  (peripheral_clock),
      .cmd_write         (cmd_write),
      .cmd_data          (cmd_data),
      .cmd_full          (cmd_full),
      .cmd_empty         (cmd_empty),
      .send_request      (send_request),
      .send_data         (send_data),
      .sending_data_flag (sending_data_flag),
      .rx_valid          (rx_valid),
      .rx_data           (rx_data),
      .ack_done          (ack_done),
      .error             (error),
      .error_code        (error_code),
      .busy              (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_sends  = 0;

   logic [7:0] exp_send [$];   // expected send_data per issue, in order
   logic [2:0] exp_evt  [$];   // expected completion per command, in order
   int         plan_q   [$];   // keyboard behaviour per issue, for the responder
   int         cur_plan [$];   // scratch: behaviour list for the next command

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: walk the command's keyboard behaviour list using the
   // protocol rules (ACK ends it, RESEND/silence retries up to MAX_RETRY
   // times, send-stage faults end it at once) and queue what must be seen.
   task automatic model_cmd(input logic [7:0] d);
      int  retries;
      int  r;
      bit  fin;
      retries = 0;
      fin     = 0;
      while (!fin) begin
         r = (cur_plan.size() > 0) ? cur_plan.pop_front() : R_SILENT;
         plan_q.push_back(r);
         exp_send.push_back(d);
         if (r == R_ACK || r == R_JUNK_ACK) begin
            exp_evt.push_back(EV_ACK);
            fin = 1;
         end else if (r == R_NOSTART) begin
            exp_evt.push_back(EV_NOSTART);
            fin = 1;
         end else if (r == R_HANG) begin
            exp_evt.push_back(EV_HANG);
            fin = 1;
         end else if (retries < TB_MAX_RETRY) begin
            retries++;
         end else begin
            exp_evt.push_back(EV_EXH);
            fin = 1;
         end
      end
      cur_plan.delete();
   endtask

   task automatic push_byte(input logic [7:0] d);
      @(negedge clock);
      cmd_write = 1'b1;
      cmd_data  = d;
   endtask

   task automatic push_end();
      @(negedge clock);
      cmd_write = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (!(exp_send.size() == 0 && exp_evt.size() == 0 && !busy && cmd_empty) && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(n >= budget), 32'd0);
      repeat (20) @(negedge clock);
   endtask

   // ---------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------
   logic       prev_req = 1'b0;
   logic [2:0] obs;

   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            if (send_request) begin
               n_sends++;
               if (prev_req) check("send_request gap", 32'(prev_req), 32'd0);
               if (exp_send.size() == 0) check("send_request unexpected", 32'(exp_send.size()), 32'd1);
               else check("send_data", 32'(send_data), 32'(exp_send.pop_front()));
            end
            if (ack_done || error) begin
               obs = ack_done ? EV_ACK : {1'b0, error_code};
               if (ack_done && error) obs = 3'b111;
               if (exp_evt.size() == 0) check("completion unexpected", 32'(exp_evt.size()), 32'd1);
               else check("completion kind", 32'(obs), 32'(exp_evt.pop_front()));
            end
         end
         prev_req = send_request;
      end
   end

   // ---------------------------------------------------------------
   // Send stage / keyboard responder
   // ---------------------------------------------------------------
   int resp_r;
   int resp_w;

   initial begin
      forever begin
         @(negedge clock);
         if (reset && send_request) begin
            resp_r = (plan_q.size() > 0) ? plan_q.pop_front() : R_SILENT;
            if (resp_r != R_NOSTART) begin
               repeat (2) @(negedge clock);
               sending_data_flag = 1'b1;
               if (resp_r == R_HANG) begin
                  resp_w = 0;
                  while (busy && resp_w < 20000) begin
                     @(negedge clock);
                     resp_w++;
                  end
                  sending_data_flag = 1'b0;
               end else begin
                  repeat (11) @(negedge clock);   // 11 bit frame
                  sending_data_flag = 1'b0;
                  repeat (3) @(negedge clock);
                  if (resp_r == R_JUNK_ACK) begin
                     rx_valid = 1'b1;
                     rx_data  = 8'($urandom_range(0, 249));
                     @(negedge clock);
                     rx_valid = 1'b0;
                     repeat (2) @(negedge clock);
                  end
                  if (resp_r != R_SILENT) begin
                     rx_data  = (resp_r == R_RESEND) ? 8'hFE : 8'hFA;
                     rx_valid = 1'b1;
                     @(negedge clock);
                     rx_valid = 1'b0;
                  end
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------
   int         s0;
   int         n;
   int         nb;
   int         k;
   int         resends;
   bit         fin;
   logic [7:0] bytes [4];

   initial begin
      // Reset state
      repeat (3) @(negedge clock);
      check("reset cmd_empty", 32'(cmd_empty), 32'd1);
      check("reset cmd_full", 32'(cmd_full), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset send_data", 32'(send_data), 32'h00);
      check("reset error_code", 32'(error_code), 32'd0);
      reset = 1'b1;
      repeat (5) @(negedge clock);

      // 0xED acknowledged first time, with push-to-issue latency
      s0 = n_sends;
      cur_plan.push_back(R_ACK);
      model_cmd(8'hED);
      push_byte(8'hED);
      push_end();
      check("cmd_empty after push edge", 32'(cmd_empty), 32'd0);
      check("no send_request at push edge", 32'(send_request), 32'd0);
      check("idle at push edge", 32'(busy), 32'd0);
      @(negedge clock);
      check("send_request one cycle later", 32'(send_request), 32'd1);
      check("busy in issue", 32'(busy), 32'd1);
      check("send_data ED", 32'(send_data), 32'hED);
      wait_idle("ED completes", 500);
      check("ED issues", 32'(n_sends - s0), 32'd1);
      check("ED cmd_empty", 32'(cmd_empty), 32'd1);

      // 0xF4 with two RESENDs then ACK
      s0 = n_sends;
      cur_plan.push_back(R_RESEND);
      cur_plan.push_back(R_RESEND);
      cur_plan.push_back(R_ACK);
      model_cmd(8'hF4);
      push_byte(8'hF4);
      push_end();
      wait_idle("F4 completes", 1000);
      check("F4 issues", 32'(n_sends - s0), 32'd3);

      // 0x05 with the send stage never starting
      cur_plan.push_back(R_NOSTART);
      model_cmd(8'h05);
      push_byte(8'h05);
      push_end();
      n = 0;
      while (!send_request && n < 50) begin
         @(negedge clock);
         n++;
      end
      n = 0;
      while (!error && n < 9000) begin
         @(negedge clock);
         n++;
      end
      check("no-start timeout window", 32'(n >= 7990 && n <= 8012), 32'd1);
      check("no-start error_code", 32'(error_code), 32'b01);
      wait_idle("05 completes", 200);

      // Five pushes into a depth-4 FIFO: the fifth is dropped
      s0 = n_sends;
      for (int i = 1; i <= 4; i++) begin
         cur_plan.push_back(R_ACK);
         model_cmd(8'(i));
      end
      for (int i = 1; i <= 4; i++) push_byte(8'(i));
      @(negedge clock);
      check("cmd_full after four", 32'(cmd_full), 32'd1);
      cmd_data = 8'h05;
      @(negedge clock);
      cmd_write = 1'b0;
      check("cmd_full after dropped push", 32'(cmd_full), 32'd1);
      wait_idle("four commands complete", 2000);
      check("four issues", 32'(n_sends - s0), 32'd4);
      check("error_code held", 32'(error_code), 32'b01);

      // 0xFF never answered: 1 + MAX_RETRY issues then exhaustion
      s0 = n_sends;
      for (int i = 0; i < 4; i++) cur_plan.push_back(R_SILENT);
      model_cmd(8'hFF);
      push_byte(8'hFF);
      push_end();
      wait_idle("FF completes", 40000);
      check("FF issues", 32'(n_sends - s0), 32'd4);
      check("FF error_code", 32'(error_code), 32'b10);
      check("FF cmd_empty", 32'(cmd_empty), 32'd1);

      // Send stage stuck busy
      cur_plan.push_back(R_HANG);
      model_cmd(8'h42);
      push_byte(8'h42);
      push_end();
      wait_idle("hang completes", 10000);
      check("hang error_code", 32'(error_code), 32'b11);

      // Random bursts with random keyboard behaviour
      for (int round = 0; round < 8; round++) begin
         nb = $urandom_range(1, 4);
         for (int j = 0; j < nb; j++) begin
            bytes[j] = 8'($urandom);
            resends  = 0;
            fin      = 0;
            while (!fin) begin
               k = $urandom_range(0, 9);
               if (k < 4) begin
                  cur_plan.push_back(R_ACK);
                  fin = 1;
               end else if (k < 6) begin
                  cur_plan.push_back(R_JUNK_ACK);
                  fin = 1;
               end else begin
                  cur_plan.push_back(R_RESEND);
                  resends++;
                  if (resends == 4) fin = 1;
               end
            end
            model_cmd(bytes[j]);
         end
         for (int j = 0; j < nb; j++) push_byte(bytes[j]);
         push_end();
         wait_idle("random burst completes", 3000);
      end

      // Reset while waiting for the keyboard reply
      exp_send.push_back(8'h3C);
      plan_q.push_back(R_SILENT);
      push_byte(8'h3C);
      push_end();
      repeat (30) @(negedge clock);
      check("in flight before reset", 32'(busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("reset busy immediate", 32'(busy), 32'd0);
      check("reset send_request immediate", 32'(send_request), 32'd0);
      check("reset send_data immediate", 32'(send_data), 32'h00);
      check("reset error_code immediate", 32'(error_code), 32'd0);
      check("reset ack_done immediate", 32'(ack_done), 32'd0);
      check("reset error immediate", 32'(error), 32'd0);
      check("reset cmd_empty immediate", 32'(cmd_empty), 32'd1);
      check("reset cmd_full immediate", 32'(cmd_full), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (50) @(negedge clock);
      check("after reset idle", 32'(busy), 32'd0);
      check("after reset empty", 32'(cmd_empty), 32'd1);
      check("after reset no pending sends", 32'(exp_send.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
